// File: rtl/uart_tx_serializer_if.sv
`default_nettype none
// ============================================================================
// uart_tx_serializer_if : TX FIFO head/pop handshake seen by the serializer
// Revision 1.0
// ============================================================================
interface uart_tx_serializer_if;
   logic       fifo_empty;
   logic [7:0] fifo_data;
   logic       pop;

   // master = serializer (consumer), slave = FIFO (producer)
   modport master (input fifo_empty, input fifo_data, output pop);
   modport slave  (output fifo_empty, output fifo_data, input pop);
endinterface
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// uart_tx_serializer : pops bytes from the TX FIFO and shifts out UART frames
// Revision 1.0
// ============================================================================
module uart_tx_serializer #(
   parameter int unsigned DIV_W = 16
) (
   input  wire              clk,
   input  wire              rstn,
   input  wire              i_tx_en,
   input  wire [DIV_W-1:0]  i_divisor,
   input  wire [1:0]        i_wlen,
   input  wire              i_parity_en,
   input  wire              i_parity_odd,
   input  wire              i_two_stop,
   uart_tx_serializer_if.master fifo,
   output logic             o_txd,
   output logic             o_busy,
   output logic             o_frame_done
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP1  = 3'd4,
      S_STOP2  = 3'd5
   } state_t;

   state_t           r_state;
   logic [DIV_W-1:0] r_cnt;
   logic [2:0]       r_bit_idx;
   logic [7:0]       r_shift;
   logic             r_par;
   logic [DIV_W-1:0] r_div;
   logic [1:0]       r_wlen;
   logic             r_par_en;
   logic             r_par_odd;
   logic             r_two_stop;
   logic             r_txd;
   logic             r_pop;
   logic             r_busy;
   logic             r_done;

   state_t           w_state_nxt;
   logic [DIV_W-1:0] w_cnt_nxt;
   logic [2:0]       w_bit_idx_nxt;
   logic [7:0]       w_shift_nxt;
   logic             w_par_nxt;
   logic [DIV_W-1:0] w_div_nxt;
   logic [1:0]       w_wlen_nxt;
   logic             w_par_en_nxt;
   logic             w_par_odd_nxt;
   logic             w_two_stop_nxt;
   logic             w_txd_nxt;
   logic             w_pop_nxt;
   logic             w_done_nxt;

   logic             w_bit_end;
   logic             w_can_start;
   logic             w_frame_end;
   logic             w_load;
   logic [2:0]       w_last_idx;

   assign w_bit_end   = (r_cnt == r_div);
   assign w_can_start = i_tx_en & ~fifo.fifo_empty;
   // Index of the final data bit: wlen+4 (0..7)
   assign w_last_idx  = {1'b0, r_wlen} + 3'd4;

   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_bit_idx_nxt  = r_bit_idx;
      w_shift_nxt    = r_shift;
      w_par_nxt      = r_par;
      w_div_nxt      = r_div;
      w_wlen_nxt     = r_wlen;
      w_par_en_nxt   = r_par_en;
      w_par_odd_nxt  = r_par_odd;
      w_two_stop_nxt = r_two_stop;
      w_txd_nxt      = r_txd;
      w_pop_nxt      = 1'b0;
      w_done_nxt     = 1'b0;
      w_frame_end    = 1'b0;
      w_load         = 1'b0;

      if (r_state != S_IDLE) begin
         w_cnt_nxt = w_bit_end ? '0 : r_cnt + DIV_W'(1);
      end

      case (r_state)
         S_IDLE: begin
            w_cnt_nxt = '0;
            if (w_can_start) begin
               w_load = 1'b1;
            end
         end
         S_START: begin
            if (w_bit_end) begin
               w_state_nxt   = S_DATA;
               w_txd_nxt     = r_shift[0];
               w_par_nxt     = r_shift[0];
               w_shift_nxt   = {1'b0, r_shift[7:1]};
               w_bit_idx_nxt = 3'd0;
            end
         end
         S_DATA: begin
            if (w_bit_end) begin
               if (r_bit_idx == w_last_idx) begin
                  if (r_par_en) begin
                     w_state_nxt = S_PARITY;
                     w_txd_nxt   = r_par ^ r_par_odd;
                  end else begin
                     w_state_nxt = S_STOP1;
                     w_txd_nxt   = 1'b1;
                  end
               end else begin
                  w_txd_nxt     = r_shift[0];
                  w_par_nxt     = r_par ^ r_shift[0];
                  w_shift_nxt   = {1'b0, r_shift[7:1]};
                  w_bit_idx_nxt = r_bit_idx + 3'd1;
               end
            end
         end
         S_PARITY: begin
            if (w_bit_end) begin
               w_state_nxt = S_STOP1;
               w_txd_nxt   = 1'b1;
            end
         end
         S_STOP1: begin
            if (w_bit_end) begin
               if (r_two_stop) begin
                  w_state_nxt = S_STOP2;
               end else begin
                  w_frame_end = 1'b1;
               end
            end
         end
         S_STOP2: begin
            if (w_bit_end) begin
               w_frame_end = 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_txd_nxt   = 1'b1;
         end
      endcase

      // Frame end may chain straight into the next start bit
      if (w_frame_end) begin
         w_done_nxt = 1'b1;
         if (w_can_start) begin
            w_load = 1'b1;
         end else begin
            w_state_nxt = S_IDLE;
            w_txd_nxt   = 1'b1;
         end
      end

      if (w_load) begin
         w_state_nxt    = S_START;
         w_txd_nxt      = 1'b0;
         w_pop_nxt      = 1'b1;
         w_cnt_nxt      = '0;
         w_bit_idx_nxt  = 3'd0;
         w_par_nxt      = 1'b0;
         w_shift_nxt    = fifo.fifo_data;
         w_div_nxt      = i_divisor;
         w_wlen_nxt     = i_wlen;
         w_par_en_nxt   = i_parity_en;
         w_par_odd_nxt  = i_parity_odd;
         w_two_stop_nxt = i_two_stop;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_bit_idx  <= 3'd0;
         r_shift    <= 8'd0;
         r_par      <= 1'b0;
         r_div      <= '0;
         r_wlen     <= 2'd0;
         r_par_en   <= 1'b0;
         r_par_odd  <= 1'b0;
         r_two_stop <= 1'b0;
         r_txd      <= 1'b1;
         r_pop      <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_bit_idx  <= w_bit_idx_nxt;
         r_shift    <= w_shift_nxt;
         r_par      <= w_par_nxt;
         r_div      <= w_div_nxt;
         r_wlen     <= w_wlen_nxt;
         r_par_en   <= w_par_en_nxt;
         r_par_odd  <= w_par_odd_nxt;
         r_two_stop <= w_two_stop_nxt;
         r_txd      <= w_txd_nxt;
         r_pop      <= w_pop_nxt;
         r_busy     <= (w_state_nxt != S_IDLE);
         r_done     <= w_done_nxt;
      end
   end

   assign fifo.pop     = r_pop;
   assign o_txd        = r_txd;
   assign o_busy       = r_busy;
   assign o_frame_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// tb_uart_tx_serializer : cycle-accurate check of UART frames against a bit-list model
// Revision 1.0
// ============================================================================
module tb_uart_tx_serializer;
   localparam int DIV_W = 16;

   logic             clk = 1'b0;
   logic             rstn;
   logic             tx_en;
   logic [DIV_W-1:0] divisor;
   logic [1:0]       wlen;
   logic             par_en;
   logic             par_odd;
   logic             two_stop;
   logic             txd;
   logic             busy;
   logic             frame_done;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   uart_tx_serializer_if fifo_if ();

   uart_tx_serializer #(.DIV_W(DIV_W)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .i_tx_en      (tx_en),
      .i_divisor    (divisor),
      .i_wlen       (wlen),
      .i_parity_en  (par_en),
      .i_parity_odd (par_odd),
      .i_two_stop   (two_stop),
      .fifo         (fifo_if),
      .o_txd        (txd),
      .o_busy       (busy),
      .o_frame_done (frame_done)
   );

   // Behavioural 16-entry FIFO feeding the DUT
   logic [7:0] mem [16];
   logic [4:0] wr_ptr = 5'd0;
   logic [4:0] rd_ptr = 5'd0;
   assign fifo_if.fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_if.fifo_data  = mem[rd_ptr[3:0]];
   always @(posedge clk) begin
      if (fifo_if.pop && (wr_ptr != rd_ptr)) rd_ptr <= rd_ptr + 5'd1;
   end

   // Expected per-cycle outputs, starting the cycle after the next edge
   logic       exp_txd[$];
   logic       exp_pop[$];
   logic       exp_busy[$];
   logic       exp_done[$];
   logic [7:0] mq[$];
   int         ptr = 0;
   logic       pend_done = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, expv, $time);
      end
   endtask

   task automatic push(input logic [7:0] b);
      mem[wr_ptr[3:0]] = b;
      wr_ptr = wr_ptr + 5'd1;
      mq.push_back(b);
   endtask

   task automatic set_cfg(input int d, input int wl, input bit pe, input bit po, input bit ts);
      divisor  = DIV_W'(d);
      wlen     = 2'(wl);
      par_en   = pe;
      par_odd  = po;
      two_stop = ts;
   endtask

   task automatic add_cycle(input logic t, input logic p, input logic b);
      exp_txd.push_back(t);
      exp_pop.push_back(p);
      exp_busy.push_back(b);
      exp_done.push_back(pend_done);
      pend_done = 1'b0;
   endtask

   // One frame from the model queue head: build the bit list, then stretch each bit
   task automatic add_frame(input int d, input int wl, input bit pe, input bit po, input bit ts);
      logic [7:0] b;
      logic       p;
      logic       bits[$];
      int         c;
      b = mq.pop_front();
      p = po;
      c = 0;
      bits.push_back(1'b0);
      for (int i = 0; i < wl + 5; i++) begin
         bits.push_back(b[i]);
         p = p ^ b[i];
      end
      if (pe) bits.push_back(p);
      bits.push_back(1'b1);
      if (ts) bits.push_back(1'b1);
      foreach (bits[k]) begin
         for (int r = 0; r <= d; r++) begin
            add_cycle(bits[k], (c == 0), 1'b1);
            c++;
         end
      end
      pend_done = 1'b1;
   endtask

   task automatic add_idle(input int n);
      for (int i = 0; i < n; i++) add_cycle(1'b1, 1'b0, 1'b0);
   endtask

   task automatic run_check(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (ptr < exp_txd.size()) begin
            chk("txd",        32'(txd),        32'(exp_txd[ptr]));
            chk("pop",        32'(fifo_if.pop), 32'(exp_pop[ptr]));
            chk("busy",       32'(busy),       32'(exp_busy[ptr]));
            chk("frame_done", 32'(frame_done), 32'(exp_done[ptr]));
            ptr++;
         end
      end
   endtask

   task automatic run_all();
      run_check(exp_txd.size() - ptr);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_txd"},  32'(txd),         32'd1);
      chk({tag, "_pop"},  32'(fifo_if.pop), 32'd0);
      chk({tag, "_busy"}, 32'(busy),        32'd0);
      chk({tag, "_done"}, 32'(frame_done),  32'd0);
   endtask

   initial begin
      int         d;
      int         wl;
      bit         pe;
      bit         po;
      bit         ts;
      logic [7:0] rb;

      rstn  = 1'b0;
      tx_en = 1'b0;
      set_cfg(0, 3, 0, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      chk_idle("reset");
      rstn = 1'b1;

      // Empty FIFO with transmitter enabled: line stays idle
      tx_en = 1'b1;
      set_cfg(3, 3, 0, 0, 0);
      add_idle(6);
      run_all();

      // 8N1 0xA5, 4 cycles per bit
      push(8'hA5);
      add_frame(3, 3, 0, 0, 0);
      add_idle(3);
      run_all();

      // 7E2 0x53
      set_cfg(2, 2, 1, 0, 1);
      push(8'h53);
      add_frame(2, 2, 1, 0, 1);
      add_idle(3);
      run_all();

      // 5O1 0x1F
      set_cfg(1, 0, 1, 1, 0);
      push(8'h1F);
      add_frame(1, 0, 1, 1, 0);
      add_idle(3);
      run_all();

      // 5E1 0xFF, upper three bits must not reach the line or the parity
      set_cfg(0, 0, 1, 0, 0);
      push(8'hFF);
      add_frame(0, 0, 1, 0, 0);
      add_idle(3);
      run_all();

      // Back-to-back 8N1 at one cycle per bit
      set_cfg(0, 3, 0, 0, 0);
      push(8'h01);
      push(8'h02);
      push(8'h03);
      add_frame(0, 3, 0, 0, 0);
      add_frame(0, 3, 0, 0, 0);
      add_frame(0, 3, 0, 0, 0);
      add_idle(3);
      run_all();

      // tx_en dropped mid-frame with two bytes still queued
      set_cfg(1, 3, 0, 0, 0);
      push(8'($urandom));
      push(8'($urandom));
      push(8'($urandom));
      add_frame(1, 3, 0, 0, 0);
      add_idle(8);
      run_check(6);
      tx_en = 1'b0;
      run_all();

      // Divisor changed during DATA: leftover two bytes drain, second at the new rate
      set_cfg(3, 3, 0, 0, 0);
      tx_en = 1'b1;
      add_frame(3, 3, 0, 0, 0);
      add_frame(7, 3, 0, 0, 0);
      add_idle(3);
      run_check(10);
      divisor = DIV_W'(7);
      run_all();

      // Reset during DATA: in-flight byte discarded, next byte sent intact
      set_cfg(3, 3, 0, 0, 0);
      push(8'($urandom));
      push(8'($urandom));
      add_frame(3, 3, 0, 0, 0);
      run_check(10);
      rstn = 1'b0;
      ptr = exp_txd.size();
      pend_done = 1'b0;
      @(posedge clk);
      #1;
      chk_idle("midreset");
      rstn = 1'b1;
      add_frame(3, 3, 0, 0, 0);
      add_idle(3);
      run_all();

      // Randomized single frames
      for (int it = 0; it < 10; it++) begin
         d  = int'($urandom_range(0, 3));
         wl = int'($urandom_range(0, 3));
         pe = 1'($urandom);
         po = 1'($urandom);
         ts = 1'($urandom);
         rb = 8'($urandom);
         set_cfg(d, wl, pe, po, ts);
         push(rb);
         add_frame(d, wl, pe, po, ts);
         add_idle(2);
         run_all();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
